// File: rtl/fir_mac8_accum.sv
// fir_mac8_accum: 8-lane multiply / adder-tree / accumulate stage of a block FIR.
//
// Each accepted 144-bit word carries 8 signed 18-bit samples (lane k = bits [18k+17:18k]).
// It is multiplied lane by lane with a matching coefficient word. The 8 products are reduced
// through a three-level registered adder tree. NWORDS words are accumulated into one output
// sample. The accumulator is scaled by SHIFT and registered as an 18-bit result, with a
// one-cycle valid pulse.
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-low reset
//   start      in   arm a new frame (restarts a running one)
//   din        in   [143:0] 8 signed samples
//   din_valid  in   din/coef valid this cycle
//   coef       in   [143:0] 8 signed coefficients, same lane packing as din
//   yout       out  [17:0] signed filter output, held until the next yvalid
//   yvalid     out  one-cycle pulse, yout updated
//   busy       out  frame armed and last word not yet accepted
//
// Optional feature macro: RND_SAT_EN. When it is defined, the output stage rounds half up
// before the shift and saturates to the 18-bit range. When it is undefined, the output is a
// plain truncated slice of the accumulator.
//
// Pipeline, for a word sampled at edge k:
//   P k, S1 k+1, S2 k+2, S3 k+3, ACC k+4, OUT k+5.
// ACCW must be at least 40 so the 39-bit tree sum fits with a sign bit to spare.

module fir_mac8_accum #(
  parameter int unsigned NWORDS = 128,
  parameter int unsigned ACCW   = 48,
  parameter int unsigned SHIFT  = 17
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [143:0] din,
  input  logic         din_valid,
  input  logic [143:0] coef,
  output logic [17:0]  yout,
  output logic         yvalid,
  output logic         busy
);

  localparam int unsigned     CNTW     = $clog2(NWORDS + 1);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NWORDS - 1);

  // ---------------------------------------------------------------------------------------------
  // Frame control
  // ---------------------------------------------------------------------------------------------
  logic [CNTW-1:0] cnt_q, cnt_d, cnt_eff;
  logic            busy_q, busy_d;
  logic            first_pend_q, first_pend_d, first_pend_eff;
  logic            accept, old_last, restart, tag_first, tag_last;

  always_comb begin
    accept   = (busy_q | start) & din_valid;
    // A word that completes the running frame belongs to that frame, even when start is high.
    old_last = busy_q & din_valid & (cnt_q == LAST_CNT);
    restart  = start & ~old_last;

    cnt_eff        = restart ? '0 : cnt_q;
    first_pend_eff = restart | first_pend_q;
    tag_first      = accept & first_pend_eff;
    tag_last       = accept & (cnt_eff == LAST_CNT);

    cnt_d        = cnt_q;
    busy_d       = busy_q;
    first_pend_d = first_pend_q;
    if (start & old_last) begin
      // The old frame finishes with this word, and the new frame is armed behind it.
      cnt_d        = '0;
      busy_d       = 1'b1;
      first_pend_d = 1'b1;
    end else if (accept) begin
      cnt_d        = tag_last ? '0 : cnt_eff + CNTW'(1);
      busy_d       = ~tag_last;
      first_pend_d = 1'b0;
    end else if (start) begin
      cnt_d        = '0;
      busy_d       = 1'b1;
      first_pend_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Datapath: lane multiply and registered adder tree (no reset needed; tags qualify it)
  // ---------------------------------------------------------------------------------------------
  logic signed [17:0] din_lane  [8];
  logic signed [17:0] coef_lane [8];
  logic signed [35:0] prod      [8];
  logic signed [35:0] p_q       [8];
  logic signed [36:0] s1_q      [4];
  logic signed [37:0] s2_q      [2];
  logic signed [38:0] s3_q;
  logic signed [ACCW-1:0] s3_ext;

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      din_lane[k]  = din[18*k +: 18];
      coef_lane[k] = coef[18*k +: 18];
      prod[k]      = $signed({{18{din_lane[k][17]}}, din_lane[k]}) *
                     $signed({{18{coef_lane[k][17]}}, coef_lane[k]});
    end
  end

  always_ff @(posedge clock) begin
    for (int k = 0; k < 8; k++) begin
      p_q[k] <= prod[k];
    end
    for (int i = 0; i < 4; i++) begin
      s1_q[i] <= {p_q[2*i][35], p_q[2*i]} + {p_q[2*i+1][35], p_q[2*i+1]};
    end
    for (int i = 0; i < 2; i++) begin
      s2_q[i] <= {s1_q[2*i][36], s1_q[2*i]} + {s1_q[2*i+1][36], s1_q[2*i+1]};
    end
    s3_q <= {s2_q[0][37], s2_q[0]} + {s2_q[1][37], s2_q[1]};
  end

  assign s3_ext = $signed({{(ACCW-39){s3_q[38]}}, s3_q});

  // ---------------------------------------------------------------------------------------------
  // Output scaling
  // ---------------------------------------------------------------------------------------------
  logic signed [ACCW-1:0] acc_q;
  logic [17:0]            yout_d;

`ifdef RND_SAT_EN
  localparam logic [ACCW-1:0] HALF = ACCW'(1) << (SHIFT - 1);

  logic signed [ACCW-1:0] rnd, shifted;
  logic                   in_range;

  always_comb begin
    rnd      = acc_q + HALF;
    shifted  = rnd >>> SHIFT;
    // The value fits 18 signed bits only when bits above bit 17 are all sign copies.
    in_range = (&shifted[ACCW-1:17]) | ~(|shifted[ACCW-1:17]);
    if (in_range) begin
      yout_d = shifted[17:0];
    end else if (shifted[ACCW-1]) begin
      yout_d = 18'h20000;
    end else begin
      yout_d = 18'h1FFFF;
    end
  end
`else
  logic unused_acc_bits;

  always_comb begin
    yout_d = acc_q[SHIFT+17:SHIFT];
  end

  // Bits outside the output slice are not needed in the truncating build.
  assign unused_acc_bits = ^acc_q;
`endif

  // ---------------------------------------------------------------------------------------------
  // Tagged state: counter, tags, accumulator, output
  // ---------------------------------------------------------------------------------------------
  // Tag index 0..3 = P, S1, S2, S3 stages.
  logic [3:0]  vld_q, first_q, last_q;
  logic        acc_last_q;
  logic [17:0] yout_q;
  logic        yvalid_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      first_pend_q <= 1'b0;
      vld_q        <= '0;
      first_q      <= '0;
      last_q       <= '0;
      acc_last_q   <= 1'b0;
      acc_q        <= '0;
      yout_q       <= '0;
      yvalid_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      first_pend_q <= first_pend_d;
      vld_q        <= {vld_q[2:0], accept};
      first_q      <= {first_q[2:0], tag_first};
      last_q       <= {last_q[2:0], tag_last};
      acc_last_q   <= vld_q[3] & last_q[3];
      // Bubbles leave the accumulator untouched; a first word replaces it.
      if (vld_q[3]) begin
        acc_q <= first_q[3] ? s3_ext : acc_q + s3_ext;
      end
      yvalid_q <= acc_last_q;
      if (acc_last_q) begin
        yout_q <= yout_d;
      end
    end
  end

  assign yout   = yout_q;
  assign yvalid = yvalid_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_fir_mac8_accum.sv
// Bench for fir_mac8_accum (NWORDS=4, ACCW=48, SHIFT=17). A frame-level model turns the
// stimulus into expected (cycle, yout) events and expected busy. Every cycle, a compare process
// checks yvalid, yout and busy against the model. Directed frames also check literal results.

module tb_fir_mac8_accum;

  localparam int NW = 4;
  localparam int SH = 17;

`ifdef RND_SAT_EN
  localparam logic [17:0] SAT_Y = 18'h1FFFF;
`else
  localparam logic [17:0] SAT_Y = 18'h3FFC0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         din_valid = 1'b0;
  logic [143:0] din = '0;
  logic [143:0] coef = '0;
  logic [17:0]  yout;
  logic         yvalid;
  logic         busy;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  fir_mac8_accum #(
    .NWORDS(NW),
    .ACCW  (48),
    .SHIFT (SH)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .din      (din),
    .din_valid(din_valid),
    .coef     (coef),
    .yout     (yout),
    .yvalid   (yvalid),
    .busy     (busy)
  );

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scale a full-precision frame sum into the 18-bit output.
  function automatic logic [17:0] expect_y(input longint s);
    longint t;
`ifdef RND_SAT_EN
    t = (s + (longint'(1) <<< (SH - 1))) >>> SH;
    if (t > 131071) t = 131071;
    else if (t < -131072) t = -131072;
`else
    t = s >>> SH;
`endif
    return t[17:0];
  endfunction

  function automatic longint dot8(input logic [143:0] d, input logic [143:0] c);
    longint acc;
    logic signed [17:0] a, b;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      a = d[18*k +: 18];
      b = c[18*k +: 18];
      acc += longint'(a) * longint'(b);
    end
    return acc;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Frame-level model
  // ---------------------------------------------------------------------------------------------
  int          cyc = 0;
  bit          m_armed = 0;
  bit          m_pend = 0;
  int          m_cnt = 0;
  longint      m_sum = 0;
  int          q_at[$];
  logic [17:0] q_y[$];
  logic [17:0] last_y = '0;

  initial begin
    bit completes_old, accept;
    forever begin
      @(posedge clock);
      cyc++;
      if (!reset) begin
        m_armed = 0;
        m_pend  = 0;
        m_cnt   = 0;
        q_at.delete();
        q_y.delete();
        last_y  = '0;
      end else begin
        completes_old = m_armed && din_valid && (m_cnt == NW - 1);
        accept        = din_valid && (m_armed || start);
        if (start && !completes_old) begin
          m_armed = 1;
          m_cnt   = 0;
          m_pend  = 1;
        end
        if (accept) begin
          if (m_pend) m_sum = dot8(din, coef);
          else m_sum += dot8(din, coef);
          m_pend = 0;
          m_cnt++;
          if (m_cnt == NW) begin
            q_at.push_back(cyc + 5);
            q_y.push_back(expect_y(m_sum));
            m_armed = 0;
            m_cnt   = 0;
          end
        end
        if (start && completes_old) begin
          m_armed = 1;
          m_cnt   = 0;
          m_pend  = 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Per-cycle compare
  // ---------------------------------------------------------------------------------------------
  int          npulse = 0;
  int          pulse_cyc = -1;
  logic [17:0] got_y = '0;

  initial begin
    logic exp_v;
    forever begin
      @(negedge clock);
      if (cyc > 0) begin
        exp_v = (q_at.size() > 0) && (q_at[0] == cyc);
        if (exp_v) begin
          last_y = q_y[0];
          void'(q_at.pop_front());
          void'(q_y.pop_front());
        end
        check("yvalid", 48'(yvalid), 48'(exp_v));
        check("yout", 48'(yout), 48'(last_y));
        check("busy", 48'(busy), 48'(m_armed));
        if (yvalid) begin
          npulse++;
          pulse_cyc = cyc;
          got_y = yout;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------------------------
  task automatic drive(input logic st, input logic dv, input logic [143:0] d,
                       input logic [143:0] c);
    start     = st;
    din_valid = dv;
    din       = d;
    coef      = c;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, '0);
  endtask

  function automatic logic [143:0] splat(input logic [17:0] v);
    return {8{v}};
  endfunction

  initial begin
    int           lw, np0;
    logic [143:0] dm, cm, c1k, d1k;

    for (int k = 0; k < 8; k++) begin
      dm[18*k +: 18] = 18'(1000 * (k + 1));
      cm[18*k +: 18] = (k % 2 == 0) ? 18'h10000 : 18'h30000;
    end
    d1k = splat(18'd1000);
    c1k = splat(18'h10000);

    // Reset state
    idle(2);
    #1;
    check("rst_yout", 48'(yout), 48'd0);
    check("rst_yvalid", 48'(yvalid), 48'd0);
    check("rst_busy", 48'(busy), 48'd0);
    reset = 1'b1;

    // T1: four back-to-back words
    np0 = npulse;
    drive(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, d1k, c1k);
    lw = cyc;
    check("t1_busy_low", 48'(busy), 48'd0);
    idle(8);
    #1;
    check("t1_npulse", 48'(npulse - np0), 48'd1);
    check("t1_latency", 48'(pulse_cyc - lw), 48'd5);
    check("t1_y", 48'(got_y), 48'(18'd16000));

    // T2: three bubbles between words
    np0 = npulse;
    drive(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, d1k, c1k);
      if (i < 3) idle(3);
    end
    lw = cyc;
    idle(8);
    #1;
    check("t2_npulse", 48'(npulse - np0), 48'd1);
    check("t2_latency", 48'(pulse_cyc - lw), 48'd5);
    check("t2_y", 48'(got_y), 48'(18'd16000));

    // T3: negative samples
    drive(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, splat(18'h3FC18), c1k);
    idle(8);
    #1;
    check("t3_y", 48'(got_y), 48'(18'h3C180));

    // T4: full-scale, wraps or saturates
    drive(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, splat(18'h1FFFF), splat(18'h1FFFF));
    idle(8);
    #1;
    check("t4_y", 48'(got_y), 48'(SAT_Y));

    // T5: restart after two words; start shares a cycle with the new first word
    np0 = npulse;
    drive(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, splat(18'd5000), c1k);
    drive(1'b1, 1'b1, d1k, c1k);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, d1k, c1k);
    lw = cyc;
    idle(8);
    #1;
    check("t5_npulse", 48'(npulse - np0), 48'd1);
    check("t5_latency", 48'(pulse_cyc - lw), 48'd5);
    check("t5_y", 48'(got_y), 48'(18'd16000));

    // T6: reset mid-frame; later words while idle are ignored
    np0 = npulse;
    drive(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, d1k, c1k);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, d1k, c1k);
    check("t6_busy", 48'(busy), 48'd0);
    idle(8);
    #1;
    check("t6_npulse", 48'(npulse - np0), 48'd0);
    check("t6_yout", 48'(yout), 48'd0);
    drive(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, d1k, c1k);
    idle(8);
    #1;
    check("t6_after_y", 48'(got_y), 48'(18'd16000));

    // T7: start with the last word; the next frame follows immediately with mixed lanes
    np0 = npulse;
    drive(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, d1k, c1k);
    drive(1'b1, 1'b1, d1k, c1k);
    check("t7_busy_rearmed", 48'(busy), 48'd1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, dm, cm);
    lw = cyc;
    idle(8);
    #1;
    check("t7_npulse", 48'(npulse - np0), 48'd2);
    check("t7_latency", 48'(pulse_cyc - lw), 48'd5);
    check("t7_y", 48'(got_y), 48'(18'h3E0C0));

    // T8: start with the first word of a frame, with mixed lanes
    drive(1'b1, 1'b1, dm, cm);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, dm, cm);
    lw = cyc;
    idle(8);
    #1;
    check("t8_latency", 48'(pulse_cyc - lw), 48'd5);
    check("t8_y", 48'(got_y), 48'(18'h3E0C0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
